acc_bank: RTL and testbench
===========================

Name: acc_bank

Overview:
- Parametrised accumulator bank for the Nibbler datapath; successor to the single 4-bit accumulator register.
- Holds NUM_ACC accumulators of WIDTH bits, loaded from the ALU result.
- Registers zero/carry flags alongside each load.
- Provides a LIFO save stack so the sequencer can push/pop an accumulator plus its flags around subroutine calls.

Parameters:
- WIDTH, 4, accumulator and ALU result width in bits (>=1)
- NUM_ACC, 2, number of accumulators (>=1); select width SEL_W = max(1, $clog2(NUM_ACC))
- STACK_DEPTH, 4, save-stack entries (>=1); count width CNT_W = $clog2(STACK_DEPTH+1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  2  operation: 00 NOP, 01 LOAD, 10 PUSH, 11 POP
- wr_sel  in  SEL_W  target accumulator for LOAD/PUSH/POP
- rd_sel  in  SEL_W  accumulator driven on acc_out
- ALU_Result  in  WIDTH  data for LOAD
- alu_carry  in  1  carry from ALU, captured on LOAD
- err_clr  in  1  clears stack_err
- acc_out  out  WIDTH  contents of acc[rd_sel]
- zero_flag  out  1  registered zero flag
- carry_flag  out  1  registered carry flag
- stack_count  out  CNT_W  occupied stack entries
- stack_full  out  1  stack_count == STACK_DEPTH
- stack_empty  out  1  stack_count == 0
- stack_err  out  1  sticky overflow/underflow indicator

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset, sampled at a rising edge, overrides op and err_clr:
  - all accumulators and flags become 0
  - stack_count becomes 0, so stack_empty=1 and stack_full=0
  - stack_err becomes 0
  - stack contents are don't-care
- Reset mid-operation discards any in-flight op.
- LOAD:
  - acc[wr_sel] <= ALU_Result
  - zero_flag <= (ALU_Result==0)
  - carry_flag <= alu_carry
  - Visible on acc_out and flags the next cycle (1-cycle latency).
- PUSH:
  - If not full: write {acc[wr_sel], zero_flag, carry_flag} to entry stack_count, then increment stack_count.
  - Accumulators and flags are unchanged.
  - If full: no state change except stack_err <= 1.
- POP:
  - If not empty: the entry at stack_count-1 is restored, i.e. acc[wr_sel] and both flags are loaded from it, then stack_count decrements.
  - If empty: no state change except stack_err <= 1.
- NOP: no state change.
- acc_out is combinational from the registered bank, indexed by rd_sel.
- rd_sel or wr_sel >= NUM_ACC (non-power-of-2 NUM_ACC):
  - Reads return 0.
  - LOAD/POP writes are dropped, and a POP still consumes its entry.
- No wrap-around: stack_count saturates at 0 and STACK_DEPTH.
- stack_err is sticky; err_clr clears it only when the same cycle does not raise a new error. A new error wins over err_clr.
- Stack entry width is WIDTH+2; the stack is LIFO.

Optional Feature:
- Macro: ACC_BYPASS_EN.
- Defined: when op==LOAD and wr_sel==rd_sel, acc_out forwards ALU_Result combinationally in that same cycle; zero_flag and carry_flag stay registered (not bypassed).
- Undefined: acc_out always reflects registered state only (1-cycle latency on all paths).

Decomposition:
- Package nibbler_acc_pkg:
  - acc_op_e enum (ACC_NOP, ACC_LOAD, ACC_PUSH, ACC_POP)
  - acc_flags_t packed struct {zero, carry}
  - default WIDTH/NUM_ACC/STACK_DEPTH localparams
- Sub-module acc_save_stack (parametrised LIFO):
  - push/pop/data in/out
  - count, full, empty, and error-pulse outputs
- acc_bank holds the register bank, flags, sticky error and op decode.

Test Plan:
- Reset then idle -> acc_out=0, zero_flag=0, carry_flag=0, stack_empty=1, stack_count=0, stack_err=0.
- LOAD wr_sel=1, ALU_Result=4'hA, alu_carry=1; then rd_sel=1 -> next cycle acc_out=4'hA, zero_flag=0, carry_flag=1; acc[0] stays 0.
- LOAD 4'h0 into acc0 -> zero_flag=1.
- PUSH acc0 (4'h3), LOAD acc0=4'hF, POP acc0 -> acc0=4'h3 with flags from push time; stack_count goes 1 then 0.
- Five PUSHes with STACK_DEPTH=4 -> stack_full=1 after the 4th; 5th sets stack_err=1, count stays 4; err_clr -> stack_err=0.
- POP on empty -> stack_err=1, accumulators unchanged.
- Assert reset while a PUSH is issued -> count=0 and bank=0 next cycle.
- ACC_BYPASS_EN defined: LOAD 4'h7 with rd_sel==wr_sel -> acc_out=4'h7 in the same cycle; undefined -> 4'h7 only one cycle later.

Source files
------------

// File: rtl/nibbler_acc_pkg.sv
// Shared types and default sizes for the Nibbler accumulator bank.
// Optional macro ACC_BYPASS_EN is consumed by acc_bank.
package nibbler_acc_pkg;

  localparam int ACC_WIDTH = 4;
  localparam int ACC_NUM   = 2;
  localparam int ACC_DEPTH = 4;

  typedef enum logic [1:0] {
    ACC_NOP  = 2'b00,
    ACC_LOAD = 2'b01,
    ACC_PUSH = 2'b10,
    ACC_POP  = 2'b11
  } acc_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
  } acc_flags_t;

endpackage

// File: rtl/acc_save_stack.sv
// LIFO save stack for accumulator + flags, saturating count.
// err pulses when a push hits full or a pop hits empty.
module acc_save_stack #(
  parameter int DW    = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] top;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign top     = AW'(count - CNT_W'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign err     = (push && full) || (pop && empty);
  assign dout    = mem[top];

  // Contents need no reset; only count defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[count[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (do_push) count <= count + CNT_W'(1);
    else if (do_pop)  count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/acc_bank.sv
// Accumulator bank with flags, sticky stack error and save stack.
// Define ACC_BYPASS_EN to forward ALU_Result to acc_out on LOAD.
module acc_bank
  import nibbler_acc_pkg::*;
#(
  parameter  int WIDTH       = ACC_WIDTH,
  parameter  int NUM_ACC     = ACC_NUM,
  parameter  int STACK_DEPTH = ACC_DEPTH,
  localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
  localparam int CNT_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic             alu_carry,
  input  logic             err_clr,
  output logic [WIDTH-1:0] acc_out,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic [CNT_W-1:0] stack_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  acc_op_e    cur_op;
  logic       is_load;
  logic       is_push;
  logic       is_pop;
  logic       pop_ok;
  logic       st_err;

  logic [WIDTH-1:0] acc [NUM_ACC];
  acc_flags_t       flags;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] rd_val;
  logic             wr_ok;
  logic             rd_ok;

  logic [WIDTH+1:0] st_din;
  logic [WIDTH+1:0] st_dout;
  logic [WIDTH-1:0] pop_val;
  acc_flags_t       pop_flags;

  assign cur_op  = acc_op_e'(op);
  assign is_load = cur_op == ACC_LOAD;
  assign is_push = cur_op == ACC_PUSH;
  assign is_pop  = cur_op == ACC_POP;
  assign pop_ok  = is_pop && !stack_empty;

  // Selects beyond NUM_ACC read as 0 and never match a write.
  always_comb begin
    wr_val = '0;
    rd_val = '0;
    wr_ok  = 1'b0;
    rd_ok  = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (wr_sel == SEL_W'(i)) begin
        wr_val = acc[i];
        wr_ok  = 1'b1;
      end
      if (rd_sel == SEL_W'(i)) begin
        rd_val = acc[i];
        rd_ok  = 1'b1;
      end
    end
  end

  assign st_din             = {wr_val, flags};
  assign {pop_val, pop_flags} = st_dout;

  acc_save_stack #(
    .DW    (WIDTH + 2),
    .DEPTH (STACK_DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (is_push),
    .pop   (is_pop),
    .din   (st_din),
    .dout  (st_dout),
    .count (stack_count),
    .full  (stack_full),
    .empty (stack_empty),
    .err   (st_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      flags     <= '0;
      stack_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (wr_sel == SEL_W'(i)) begin
          if (is_load)     acc[i] <= ALU_Result;
          else if (pop_ok) acc[i] <= pop_val;
        end
      end
      if (is_load && wr_ok)
        flags <= '{zero: (ALU_Result == '0), carry: alu_carry};
      else if (pop_ok && wr_ok)
        flags <= pop_flags;
      if (st_err)       stack_err <= 1'b1;
      else if (err_clr) stack_err <= 1'b0;
    end
  end

`ifdef ACC_BYPASS_EN
  assign acc_out = (is_load && rd_ok && wr_sel == rd_sel)
                 ? ALU_Result : rd_val;
`else
  logic unused_rd_ok;
  assign unused_rd_ok = rd_ok;
  assign acc_out      = rd_val;
`endif

  assign zero_flag  = flags.zero;
  assign carry_flag = flags.carry;

endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank against a queue-based reference model.
module tb_acc_bank;

  localparam int W = 4;
  localparam int N = 2;
  localparam int D = 4;

  localparam logic [1:0] NOP  = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PUSH = 2'd2;
  localparam logic [1:0] POP  = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   op;
  logic [0:0]   wr_sel;
  logic [0:0]   rd_sel;
  logic [W-1:0] ALU_Result;
  logic         alu_carry;
  logic         err_clr;
  logic [W-1:0] acc_out;
  logic         zero_flag;
  logic         carry_flag;
  logic [2:0]   stack_count;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_err;

  always #5 clk = ~clk;

  acc_bank dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .wr_sel      (wr_sel),
    .rd_sel      (rd_sel),
    .ALU_Result  (ALU_Result),
    .alu_carry   (alu_carry),
    .err_clr     (err_clr),
    .acc_out     (acc_out),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .stack_count (stack_count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  typedef struct {
    logic [W-1:0] acc;
    bit           z;
    bit           c;
    int           cnt;
    bit           full;
    bit           empty;
    bit           err;
  } exp_t;

  typedef struct {
    logic [W-1:0] v;
    bit           z;
    bit           c;
  } ent_t;

  exp_t         sb[$];
  ent_t         stk[$];
  logic [W-1:0] m_acc [N];
  bit           m_z;
  bit           m_c;
  bit           m_err;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic step(input logic [1:0] o, input int w, input int r,
                      input logic [W-1:0] a, input bit cy,
                      input bit clr, input bit rst);
    exp_t e;
    ent_t en;
    bit   ne;
    @(negedge clk);
    op         = o;
    wr_sel     = w[0:0];
    rd_sel     = r[0:0];
    ALU_Result = a;
    alu_carry  = cy;
    err_clr    = clr;
    reset      = rst;
    #1;
    if (!rst && o == LOAD && w == r) begin
`ifdef ACC_BYPASS_EN
      chk("same_cycle_bypass", acc_out, a);
`else
      chk("same_cycle_nobypass", acc_out, m_acc[r]);
`endif
    end
    ne = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) m_acc[i] = '0;
      m_z = 0;
      m_c = 0;
      m_err = 0;
      stk.delete();
    end else begin
      case (o)
        LOAD: begin
          m_acc[w] = a;
          m_z = (a == 0);
          m_c = cy;
        end
        PUSH: begin
          if (stk.size() == D) ne = 1'b1;
          else begin
            en.v = m_acc[w];
            en.z = m_z;
            en.c = m_c;
            stk.push_back(en);
          end
        end
        POP: begin
          if (stk.size() == 0) ne = 1'b1;
          else begin
            en = stk.pop_back();
            m_acc[w] = en.v;
            m_z = en.z;
            m_c = en.c;
          end
        end
        default: ;
      endcase
      if (ne) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    e.acc   = m_acc[r];
    e.z     = m_z;
    e.c     = m_c;
    e.cnt   = stk.size();
    e.full  = (stk.size() == D);
    e.empty = (stk.size() == 0);
    e.err   = m_err;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("acc_out", acc_out, e.acc);
        chk("zero_flag", zero_flag, e.z);
        chk("carry_flag", carry_flag, e.c);
        chk("stack_count", stack_count, e.cnt);
        chk("stack_full", stack_full, e.full);
        chk("stack_empty", stack_empty, e.empty);
        chk("stack_err", stack_err, e.err);
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    op = NOP;
    wr_sel = '0;
    rd_sel = '0;
    ALU_Result = '0;
    alu_carry = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < N; i++) m_acc[i] = '0;

    step(NOP, 0, 0, 4'h0, 0, 0, 1);
    step(NOP, 0, 0, 4'h0, 0, 0, 0);
    step(NOP, 0, 1, 4'h0, 0, 0, 0);

    step(LOAD, 1, 1, 4'hA, 1, 0, 0);
    step(NOP, 0, 1, 4'h0, 0, 0, 0);
    step(NOP, 0, 0, 4'h0, 0, 0, 0);

    step(LOAD, 0, 0, 4'h0, 0, 0, 0);
    step(LOAD, 0, 0, 4'h3, 0, 0, 0);
    step(PUSH, 0, 0, 4'h0, 0, 0, 0);
    step(LOAD, 0, 0, 4'hF, 1, 0, 0);
    step(POP, 0, 0, 4'h0, 0, 0, 0);

    for (int k = 0; k < 5; k++) step(PUSH, k % 2, 0, 4'h0, 0, 0, 0);
    step(NOP, 0, 1, 4'h0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(POP, 1, 1, 4'h0, 0, 0, 0);
    step(POP, 0, 0, 4'h0, 0, 1, 0);
    step(NOP, 0, 1, 4'h0, 0, 1, 0);

    step(PUSH, 1, 1, 4'h0, 0, 0, 0);
    step(PUSH, 1, 1, 4'h0, 0, 0, 1);
    step(NOP, 0, 1, 4'h0, 0, 0, 0);
    step(LOAD, 0, 0, 4'h7, 0, 0, 0);
    step(NOP, 0, 0, 4'h0, 0, 0, 0);

    for (int k = 0; k < 600; k++) begin
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), 4'($urandom),
           bit'($urandom_range(0, 1)), ($urandom % 4) == 0,
           ($urandom % 50) == 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
